// File: rtl/regfile_load_sequencer.sv
// regfile_load_sequencer: button-driven sequential load of an 8-entry register file, then a dwell-paced readback scan.
// Optional debounce of the store button is enabled with `define REGFILE_LOAD_SEQUENCER_DEBOUNCE_EN.
module regfile_load_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  store,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] read_register,
  output logic                  loading,
  output logic                  load_done
);
  localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = '1;

  typedef enum logic [1:0] {LOAD, WRITE, SCAN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [DW-1:0]           dwell;
  logic                    store_s;
  logic                    store_q;
  logic                    rise;

`ifdef REGFILE_LOAD_SEQUENCER_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]     sync;
  logic           db;
  logic [DBW-1:0] db_cnt;
  // synchronize the raw button, then only flip the level after a run of identical samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      db     <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], store};
      if (sync[1] == db) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        db     <= sync[1];
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
  assign store_s = db;
`else
  assign store_s = store;
`endif

  assign rise = store_s & ~store_q;

  // sequencer: load each register on a press, then scan read addresses; clear overrides everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= LOAD;
      wr_ptr         <= '0;
      dwell          <= '0;
      store_q        <= 1'b0;
      write_enable   <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      read_register  <= '0;
      loading        <= 1'b1;
      load_done      <= 1'b0;
    end else begin
      store_q <= store_s;
      if (clear) begin
        state         <= LOAD;
        wr_ptr        <= '0;
        dwell         <= '0;
        read_register <= '0;
        write_enable  <= 1'b0;
        load_done     <= 1'b0;
        loading       <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            read_register <= wr_ptr;
            if (rise) begin
              state          <= WRITE;
              write_register <= wr_ptr;
              write_data     <= din;
              write_enable   <= 1'b1;
            end
          end
          WRITE: begin
            write_enable <= 1'b0;
            if (wr_ptr == LAST_REG) begin
              state         <= SCAN;
              load_done     <= 1'b1;
              loading       <= 1'b0;
              read_register <= '0;
              dwell         <= '0;
            end else begin
              state         <= LOAD;
              wr_ptr        <= wr_ptr + 1'b1;
              read_register <= wr_ptr + 1'b1;
            end
          end
          default: begin
            if (rise) begin
              state         <= LOAD;
              wr_ptr        <= '0;
              dwell         <= '0;
              read_register <= '0;
              load_done     <= 1'b0;
              loading       <= 1'b1;
            end else if (dwell == DWELL_LAST) begin
              dwell         <= '0;
              read_register <= read_register + 1'b1;
            end else dwell <= dwell + 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_regfile_load_sequencer.sv
// tb_regfile_load_sequencer: scoreboard bench; stimulus queues expected writes, a monitor checks each write strobe.
module tb_regfile_load_sequencer;
  logic       clock = 1'b0;
  logic       reset;
  logic       store;
  logic       clear;
  logic [7:0] din;
  logic       write_enable;
  logic [2:0] write_register;
  logic [7:0] write_data;
  logic [2:0] read_register;
  logic       loading;
  logic       load_done;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;

  regfile_load_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .DWELL_CYCLES(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .store(store), .clear(clear), .din(din),
    .write_enable(write_enable), .write_register(write_register), .write_data(write_data),
    .read_register(read_register), .loading(loading), .load_done(load_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input int r, input int d, input int hi, input int lo);
    din = 8'(d);
    exp_q.push_back({3'(r), 8'(d)});
    store = 1'b1;
    repeat (hi) tick();
    store = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic check_reset_values();
    check("rst_we", int'(write_enable), 0);
    check("rst_wreg", int'(write_register), 0);
    check("rst_wdata", int'(write_data), 0);
    check("rst_rreg", int'(read_register), 0);
    check("rst_loading", int'(loading), 1);
    check("rst_done", int'(load_done), 0);
  endtask

  // monitor: every write strobe must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset && write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: reg %0d data %0h, expected no write", write_register, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_reg", int'(write_register), int'(mon_e[10:8]));
        check("write_data", int'(write_data), int'(mon_e[7:0]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    store = 1'b0;
    clear = 1'b0;
    din   = '0;
    #12;
    check_reset_values();
    reset = 1'b1;
    tick();
`ifdef REGFILE_LOAD_SEQUENCER_DEBOUNCE_EN
    store = 1'b1;
    repeat (3) tick();
    store = 1'b0;
    repeat (20) tick();
    din = 8'h99;
    exp_q.push_back({3'd0, 8'h99});
    store = 1'b1;
    n = 0;
    while (!write_enable && n < 40) begin
      tick();
      n++;
    end
    check("db_latency", n, 11);
    tick();
    store = 1'b0;
    repeat (30) tick();
    check("queue_drained", exp_q.size(), 0);
`else
    for (int i = 0; i < 7; i++) press(i, 16 * i + 1, 3, 5);
    din = 8'h71;
    exp_q.push_back({3'd7, 8'h71});
    store = 1'b1;
    tick();
    tick();
    check("scan_done", int'(load_done), 1);
    check("scan_loading", int'(loading), 0);
    store = 1'b0;
    for (int k = 0; k < 36; k++) begin
      check("scan_rreg", int'(read_register), (k / 4) % 8);
      tick();
    end
    check("queue_drained", exp_q.size(), 0);
    store = 1'b1;
    tick();
    check("rescan_done", int'(load_done), 0);
    check("rescan_loading", int'(loading), 1);
    check("rescan_rreg", int'(read_register), 0);
    store = 1'b0;
    tick();
    press(0, 8'hA0, 3, 5);
    press(1, 8'hA1, 3, 5);
    din = 8'h5A;
    exp_q.push_back({3'd2, 8'h5A});
    store = 1'b1;
    repeat (20) tick();
    store = 1'b0;
    repeat (3) tick();
    check("hold_rreg", int'(read_register), 3);
    check("queue_drained", exp_q.size(), 0);
    din = 8'hEE;
    clear = 1'b1;
    store = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_rreg", int'(read_register), 0);
    check("clr_done", int'(load_done), 0);
    check("clr_loading", int'(loading), 1);
    repeat (3) tick();
    store = 1'b0;
    tick();
    press(0, 8'h3C, 3, 5);
    din = 8'h77;
    store = 1'b1;
    tick();
    check("pre_rst_we", int'(write_enable), 1);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values();
    #4;
    reset = 1'b1;
    store = 1'b0;
    tick();
    tick();
    press(0, 8'h42, 3, 5);
    check("queue_drained", exp_q.size(), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
